// File: rtl/arb_pkg.sv
// Shared types for the 2-way arbiter and its requester-side clients.
package arb_pkg;
  localparam int ARB_N = 2;

  typedef logic [ARB_N-1:0] arb_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } client_state_e;
endpackage

// File: rtl/arb_job_fifo.sv
// Small job queue. There is no bypass path, so a pushed entry reaches
// dout one cycle after the push. A push when full or a pop when empty is
// ignored.
module arb_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Storage holds no state that matters after reset, so it is left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; the pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/arb_client.sv
// Requester-side agent: queues ownership jobs, requests the bus, and holds it
// for job_len+1 beats. It handles grant loss (preemption) and a bounded
// wait for grant (timeout).
module arb_client
  import arb_pkg::*;
#(
  parameter int CLIENT_ID  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  input  arb_vec_t         grant,
  output arb_vec_t         request,
  output logic             owned,
  output logic             done,
  output logic             timeout_err,
  output logic             preempted
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  client_state_e     state_q, state_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  logic              owned_q, owned_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              pre_q, pre_d;
  logic              alive_q;

  logic              q_full, q_empty, q_pop;
  logic [LEN_W-1:0]  q_dout;
  logic              my_grant;
  logic              grant_unused;

  assign my_grant     = grant[CLIENT_ID];
  assign grant_unused = ^grant;

  // alive_q keeps job_ready low while reset is held and for the reset cycle itself.
  assign job_ready = alive_q && !q_full;

  arb_job_fifo #(.DEPTH(FIFO_DEPTH), .W(LEN_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (job_valid && job_ready),
    .pop   (q_pop),
    .din   (job_len),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // Next state: the grant check comes before the timeout or beat checks, so a grant on the last wait cycle wins.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    req_d   = req_q;
    owned_d = owned_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    pre_d   = 1'b0;
    q_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          beats_d = q_dout;
          wait_d  = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (my_grant) begin
          owned_d = 1'b1;
          state_d = OWN;
        end else if (wait_q == WAIT_LAST) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      OWN: begin
        if (!my_grant) begin
          // Keep the remaining beats; the request stays up to win the bus back.
          pre_d   = 1'b1;
          owned_d = 1'b0;
          wait_d  = '0;
          state_d = REQ;
        end else if (beats_q == '0) begin
          req_d   = 1'b0;
          owned_d = 1'b0;
          state_d = RELEASE;
        end else begin
          beats_d = beats_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!my_grant) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beats_q <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      owned_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      pre_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      owned_q <= owned_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      pre_q   <= pre_d;
      alive_q <= 1'b1;
    end
  end

  // Only this client's bit of the request vector is ever driven.
  always_comb begin
    request            = '0;
    request[CLIENT_ID] = req_q;
  end

  assign owned       = owned_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign preempted   = pre_q;
endmodule

// File: tb/tb_arb_client.sv
// Directed bench: dut0 is the high-priority client behind a registered
// priority arbiter model; dut1 is the low-priority client with a grant that
// the bench drives by hand (or switches to the arbiter model).
module tb_arb_client;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic jv0 = 1'b0, jv1 = 1'b0;
  logic [3:0] jl0 = '0, jl1 = '0;
  logic jr0, jr1, own0, own1, dn0, dn1, te0, te1, pe0, pe1;
  arb_vec_t r0, r1, g0, g1;
  arb_vec_t g0_arb = '0, g1_arb = '0, gman1 = '0;
  logic auto1 = 1'b0;

  int total = 0, bad = 0;

  arb_client #(.CLIENT_ID(0), .FIFO_DEPTH(4), .LEN_W(4), .TIMEOUT(15)) dut0 (
    .clk(clk), .reset(reset), .job_valid(jv0), .job_len(jl0), .job_ready(jr0),
    .grant(g0), .request(r0), .owned(own0), .done(dn0),
    .timeout_err(te0), .preempted(pe0));

  arb_client #(.CLIENT_ID(1), .FIFO_DEPTH(4), .LEN_W(4), .TIMEOUT(15)) dut1 (
    .clk(clk), .reset(reset), .job_valid(jv1), .job_len(jl1), .job_ready(jr1),
    .grant(g1), .request(r1), .owned(own1), .done(dn1),
    .timeout_err(te1), .preempted(pe1));

  // Registered fixed-priority arbiter model, bit 0 highest.
  always @(posedge clk) begin
    g0_arb <= r0[0] ? 2'b01 : (r0[1] ? 2'b10 : 2'b00);
    g1_arb <= r1[0] ? 2'b01 : (r1[1] ? 2'b10 : 2'b00);
  end
  assign g0 = g0_arb;
  assign g1 = auto1 ? g1_arb : gman1;

  // Monitors: owned run lengths, done pulse counts, done/request overlap.
  int run0 = 0, run1 = 0, dcnt0 = 0, dcnt1 = 0, ovl0 = 0;
  int runs0[$], runs1[$];
  always @(negedge clk) begin
    if (own0) run0++; else if (run0 > 0) begin runs0.push_back(run0); run0 = 0; end
    if (own1) run1++; else if (run1 > 0) begin runs1.push_back(run1); run1 = 0; end
    if (dn0) dcnt0++;
    if (dn1) dcnt1++;
    if (dn0 && r0 != 2'b00) ovl0++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (r0 !== 2'b00 || own0 !== 1'b0 || dn0 !== 1'b0 || te0 !== 1'b0 || pe0 !== 1'b0) begin bad++; $display("FAIL reset_out0: got req=%b own=%b dn=%b te=%b pe=%b want all 0", r0, own0, dn0, te0, pe0); end
    total++; if (jr0 !== 1'b0 || jr1 !== 1'b0) begin bad++; $display("FAIL reset_ready_held: got %b%b want 00", jr0, jr1); end
    reset = 1'b0;
    step();
    total++; if (jr0 !== 1'b1 || jr1 !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b%b want 11", jr0, jr1); end
    total++; if (r1 !== 2'b00 || own1 !== 1'b0) begin bad++; $display("FAIL reset_out1: got req=%b own=%b want 00/0", r1, own1); end
  endtask

  task automatic test_basic();
    int b = runs0.size();
    int d = dcnt0;
    jv0 = 1'b1; jl0 = 4'd2; step(); jv0 = 1'b0;                         // E0
    total++; if (r0 !== 2'b00) begin bad++; $display("FAIL basic_e0_req: got %b want 00", r0); end
    step();                                                              // E1
    total++; if (r0 !== 2'b01 || own0 !== 1'b0) begin bad++; $display("FAIL basic_e1: got req=%b own=%b want 01/0", r0, own0); end
    step();                                                              // E2
    total++; if (own0 !== 1'b0) begin bad++; $display("FAIL basic_e2_own: got %b want 0", own0); end
    for (int i = 0; i < 3; i++) begin                                    // E3..E5
      step();
      total++; if (own0 !== 1'b1 || r0 !== 2'b01) begin bad++; $display("FAIL basic_own_beat%0d: got own=%b req=%b want 1/01", i, own0, r0); end
    end
    step();                                                              // E6
    total++; if (own0 !== 1'b0 || r0 !== 2'b00 || dn0 !== 1'b0) begin bad++; $display("FAIL basic_e6: got own=%b req=%b dn=%b want 0/00/0", own0, r0, dn0); end
    step();                                                              // E7
    total++; if (dn0 !== 1'b0) begin bad++; $display("FAIL basic_e7_done: got %b want 0", dn0); end
    step();                                                              // E8
    total++; if (dn0 !== 1'b1 || r0 !== 2'b00) begin bad++; $display("FAIL basic_e8_done: got dn=%b req=%b want 1/00", dn0, r0); end
    step();                                                              // E9
    total++; if (dn0 !== 1'b0) begin bad++; $display("FAIL basic_e9_done: got %b want 0", dn0); end
    total++; if (dcnt0 - d !== 1 || runs0.size() != b + 1) begin bad++; $display("FAIL basic_counts: got done=%0d runs=%0d want 1/1", dcnt0 - d, runs0.size() - b); end
  endtask

  task automatic test_len_edges();
    int lens[2] = '{0, 15};
    int exp[2]  = '{1, 16};
    for (int k = 0; k < 2; k++) begin
      int b = runs0.size();
      int d = dcnt0;
      jv0 = 1'b1; jl0 = 4'(lens[k]); step(); jv0 = 1'b0;
      repeat (40) step();
      total++;
      if (runs0.size() != b + 1) begin bad++; $display("FAIL len%0d_runs: got %0d runs want 1", lens[k], runs0.size() - b); end
      else if (runs0[b] != exp[k]) begin bad++; $display("FAIL len%0d_owned: got %0d cycles want %0d", lens[k], runs0[b], exp[k]); end
      total++; if (dcnt0 - d !== 1) begin bad++; $display("FAIL len%0d_done: got %0d want 1", lens[k], dcnt0 - d); end
    end
  endtask

  task automatic test_timeout();
    int d = dcnt1;
    int b = runs1.size();
    int reqc = 0;
    auto1 = 1'b0; gman1 = 2'b00;
    jv1 = 1'b1; jl1 = 4'd1; step();                                     // E0: push A
    jl1 = 4'd2; step(); jv1 = 1'b0;                                      // E1: push B, pop A
    total++; if (r1 !== 2'b10 || te1 !== 1'b0) begin bad++; $display("FAIL tmo_e1: got req=%b te=%b want 10/0", r1, te1); end
    if (r1 == 2'b10) reqc++;
    for (int i = 2; i <= 15; i++) begin
      step();
      if (r1 == 2'b10) reqc++;
    end
    total++; if (r1 !== 2'b10 || te1 !== 1'b0) begin bad++; $display("FAIL tmo_e15: got req=%b te=%b want 10/0", r1, te1); end
    total++; if (reqc != 15) begin bad++; $display("FAIL tmo_req_cycles: got %0d want 15", reqc); end
    step();                                                              // E16
    total++; if (r1 !== 2'b00 || te1 !== 1'b1) begin bad++; $display("FAIL tmo_e16: got req=%b te=%b want 00/1", r1, te1); end
    step();                                                              // E17
    total++; if (r1 !== 2'b10 || te1 !== 1'b0) begin bad++; $display("FAIL tmo_e17_next: got req=%b te=%b want 10/0", r1, te1); end
    total++; if (dcnt1 - d !== 0) begin bad++; $display("FAIL tmo_no_done: got %0d want 0", dcnt1 - d); end
    auto1 = 1'b1;
    repeat (15) step();
    total++; if (dcnt1 - d !== 1) begin bad++; $display("FAIL tmo_jobB_done: got %0d want 1", dcnt1 - d); end
    total++;
    if (runs1.size() != b + 1) begin bad++; $display("FAIL tmo_jobB_runs: got %0d want 1", runs1.size() - b); end
    else if (runs1[b] != 3) begin bad++; $display("FAIL tmo_jobB_owned: got %0d want 3", runs1[b]); end
    auto1 = 1'b0; gman1 = 2'b00;
  endtask

  task automatic test_preempt();
    int b = runs1.size();
    int d = dcnt1;
    jv1 = 1'b1; jl1 = 4'd5; step(); jv1 = 1'b0;                         // E0
    step();                                                              // E1
    total++; if (r1 !== 2'b10) begin bad++; $display("FAIL pre_e1_req: got %b want 10", r1); end
    gman1 = 2'b10;
    step(); step(); step();                                              // E2..E4
    total++; if (own1 !== 1'b1) begin bad++; $display("FAIL pre_e4_own: got %b want 1", own1); end
    gman1 = 2'b01;
    step();                                                              // E5
    total++; if (pe1 !== 1'b1 || own1 !== 1'b0 || r1 !== 2'b10) begin bad++; $display("FAIL pre_e5: got pe=%b own=%b req=%b want 1/0/10", pe1, own1, r1); end
    gman1 = 2'b10;
    step();                                                              // E6
    total++; if (pe1 !== 1'b0 || own1 !== 1'b1) begin bad++; $display("FAIL pre_e6: got pe=%b own=%b want 0/1", pe1, own1); end
    step(); step(); step();                                              // E7..E9
    step();                                                              // E10
    total++; if (own1 !== 1'b0 || r1 !== 2'b00) begin bad++; $display("FAIL pre_e10: got own=%b req=%b want 0/00", own1, r1); end
    gman1 = 2'b00;
    step();                                                              // E11
    total++; if (dn1 !== 1'b1) begin bad++; $display("FAIL pre_e11_done: got %b want 1", dn1); end
    step();
    total++;
    if (runs1.size() != b + 2) begin bad++; $display("FAIL pre_runs: got %0d want 2", runs1.size() - b); end
    else if (runs1[b] != 3 || runs1[b+1] != 4) begin bad++; $display("FAIL pre_owned: got %0d+%0d want 3+4", runs1[b], runs1[b+1]); end
    total++; if (dcnt1 - d !== 1) begin bad++; $display("FAIL pre_done_cnt: got %0d want 1", dcnt1 - d); end
  endtask

  task automatic test_back_to_back();
    int b = runs0.size();
    int d = dcnt0;
    int n = 0;
    int exp[5] = '{16, 2, 3, 4, 5};
    jv0 = 1'b1; jl0 = 4'd15; step(); jv0 = 1'b0;
    while (!own0 && n < 10) begin step(); n++; end
    total++; if (own0 !== 1'b1) begin bad++; $display("FAIL b2b_own_wait: got %b want 1 within 10 cycles", own0); end
    for (int i = 0; i < 5; i++) begin
      jv0 = 1'b1; jl0 = 4'(i + 1);
      total++; if (jr0 !== (i < 4)) begin bad++; $display("FAIL b2b_ready%0d: got %b want %b", i, jr0, (i < 4)); end
      step();
    end
    jv0 = 1'b0;
    total++; if (jr0 !== 1'b0) begin bad++; $display("FAIL b2b_full: got %b want 0", jr0); end
    repeat (80) step();
    total++; if (dcnt0 - d !== 5) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 5", dcnt0 - d); end
    total++;
    if (runs0.size() != b + 5) begin bad++; $display("FAIL b2b_runs: got %0d want 5", runs0.size() - b); end
    else begin
      for (int i = 0; i < 5; i++)
        if (runs0[b+i] != exp[i]) begin bad++; $display("FAIL b2b_order%0d: got %0d want %0d", i, runs0[b+i], exp[i]); break; end
    end
    total++; if (ovl0 !== 0) begin bad++; $display("FAIL b2b_idle_gap: got %0d overlaps want 0", ovl0); end
  endtask

  task automatic test_reset_own();
    int d;
    int n = 0;
    jv0 = 1'b1; jl0 = 4'd10; step(); jv0 = 1'b0;
    while (!own0 && n < 10) begin step(); n++; end
    total++; if (own0 !== 1'b1) begin bad++; $display("FAIL rst_own_wait: got %b want 1 within 10 cycles", own0); end
    step(); step();
    #3 reset = 1'b1;
    #1;
    total++; if (r0 !== 2'b00 || own0 !== 1'b0 || jr0 !== 1'b0) begin bad++; $display("FAIL rst_async: got req=%b own=%b rdy=%b want 00/0/0", r0, own0, jr0); end
    d = dcnt0;
    step();
    reset = 1'b0;
    step();
    total++; if (jr0 !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", jr0); end
    repeat (20) step();
    total++; if (dcnt0 - d !== 0 || r0 !== 2'b00) begin bad++; $display("FAIL rst_no_done: got done=%0d req=%b want 0/00", dcnt0 - d, r0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_edges();
    test_timeout();
    test_preempt();
    test_back_to_back();
    test_reset_own();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
